// File: rtl/aes_pkg.sv
// Shared AES constants and the SubBytes sequencer state encoding.
package aes_pkg;

    localparam int NWORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_HOLD = 2'd2
    } sub_state_t;

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box applied to the four bytes of one 32-bit word.
module aes_sbox (
    input  logic [31:0] word,
    output logic [31:0] sub_word
);

    // Entry for byte value v sits at bits [(255-v)*8 +: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            logic [7:0] lane;
            assign lane = word[gi*8 +: 8];
            assign sub_word[gi*8 +: 8] = SBOX_TABLE[{~lane, 3'b000} +: 8];
        end
    endgenerate

endmodule

// File: rtl/aes_subbytes_seq.sv
// Word-serial AES SubBytes: one shared S-box walks words 0..3 of the state,
// then the result is held until the downstream stage takes it.
module aes_subbytes_seq
    import aes_pkg::*;
#(
    parameter int NWORDS = aes_pkg::NWORDS
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy
);

    localparam logic [1:0] LAST_WORD = 2'(NWORDS - 1);

    sub_state_t   state_reg, state_next;
    logic [1:0]   cnt_reg, cnt_next;
    logic [127:0] data_reg, data_next;
    logic [31:0]  sbox_in, sbox_out;
    logic [6:0]   word_lsb;

    // Word 0 occupies the top 32 bits, so word i starts at bit (3-i)*32.
    assign word_lsb = {~cnt_reg, 5'b00000};

    always_comb begin
        sbox_in = '0;
        if (state_reg == ST_SUB) begin
            sbox_in = data_reg[word_lsb +: 32];
        end
    end

    aes_sbox u_sbox (
        .word     (sbox_in),
        .sub_word (sbox_out)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    data_next  = in_block;
                    cnt_next   = '0;
                    state_next = ST_SUB;
                end
            end
            ST_SUB: begin
                data_next[word_lsb +: 32] = sbox_out;
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == LAST_WORD) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_HOLD);
    assign busy      = (state_reg != ST_IDLE);
    assign out_block = data_reg;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Self-checking bench: S-box derived from GF(2^8) arithmetic, transaction-level
// model of the accept / 4-step substitute / hold behaviour, randomized traffic.
module tb_aes_subbytes_seq;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_block = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_block;
    logic         busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] sbox_ref [256];

    localparam logic [127:0] V_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] V_OUT = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;
    localparam logic [127:0] Z_OUT = {16{8'h63}};
    localparam logic [127:0] P_IN  = 128'h52000000_00000000_00000000_00000000;
    localparam logic [127:0] P_OUT = 128'h00636363_63636363_63636363_63636363;

    aes_subbytes_seq #(.NWORDS(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Multiplicative inverse in GF(2^8) followed by the AES affine transform.
    function automatic logic [7:0] sbox_math(input logic [7:0] v);
        logic [7:0] inv = '0;
        for (int y = 1; y < 256; y++) begin
            if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    // Words 0..k-1 substituted, the rest untouched (word 0 is the top 32 bits).
    function automatic logic [127:0] partial_sub(input logic [127:0] b, input int k);
        logic [127:0] r = b;
        for (int w = 0; w < 4; w++) begin
            if (w < k) begin
                for (int j = 0; j < 4; j++) begin
                    r[127 - 32*w - 8*j -: 8] = sbox_ref[b[127 - 32*w - 8*j -: 8]];
                end
            end
        end
        return r;
    endfunction

    // Model: whether a block is in flight, edges since acceptance, last result.
    bit           m_have = 1'b0;
    int           m_steps = 0;
    logic [127:0] m_blk = '0;
    logic [127:0] m_img = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_have  <= 1'b0;
            m_steps <= 0;
            m_img   <= '0;
        end else if (!m_have) begin
            if (in_valid) begin
                m_have  <= 1'b1;
                m_blk   <= in_block;
                m_steps <= 0;
            end
        end else if (m_steps < 4) begin
            m_steps <= m_steps + 1;
        end else if (out_ready) begin
            m_have <= 1'b0;
            m_img  <= partial_sub(m_blk, 4);
            $display("[TB] t=%0t block %h -> %h", $time, m_blk, partial_sub(m_blk, 4));
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, !m_have);
        check("out_valid", out_valid, m_have && (m_steps == 4));
        check("busy", busy, m_have);
        check("out_block", out_block, m_have ? partial_sub(m_blk, m_steps) : m_img);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic send_expect(input string name, input logic [127:0] blk, input logic [127:0] exp);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_block  = blk;
        tick();
        in_valid  = 1'b0;
        wait_out_valid(lat);
        check({name, " latency"}, 128'(lat), 128'd4);
        check({name, " result"}, out_block, exp);
        tick();
        check({name, " back to idle"}, in_ready, 1'b1);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [127:0] a;
        for (int i = 0; i < 256; i++) sbox_ref[i] = sbox_math(8'(i));

        check("model sbox 53", 128'(sbox_ref[8'h53]), 128'hed);
        check("model vector", partial_sub(V_IN, 4), V_OUT);
        check("model zeros", partial_sub('0, 4), Z_OUT);
        check("model lanes", partial_sub(P_IN, 4), P_OUT);

        // Edges under reset must not accept, even with in_valid high.
        in_valid = 1'b1;
        in_block = V_IN;
        tick(); tick();
        check("reset in_ready", in_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_block", out_block, '0);
        reset_n = 1'b1;
        tick();
        check("first edge accepts", busy, 1'b1);
        in_valid = 1'b0;
        wait_out_valid(lat);
        check("vector latency", 128'(lat), 128'd4);
        check("vector result", out_block, V_OUT);

        // Backpressure: hold steady for 10 cycles, then a single ready pulse.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold out_valid", out_valid, 1'b1);
            check("hold stable", out_block, V_OUT);
            check("hold in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pulse idle in_ready", in_ready, 1'b1);
        check("pulse idle out_valid", out_valid, 1'b0);

        send_expect("zeros", '0, Z_OUT);
        send_expect("lanes", P_IN, P_OUT);

        // A second block offered while busy must be ignored.
        a = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_block  = a;
        tick();
        in_block  = ~a;
        wait_out_valid(lat);
        in_valid  = 1'b0;
        check("ignore latency", 128'(lat), 128'd4);
        check("ignore result", out_block, partial_sub(a, 4));
        tick();
        out_ready = 1'b0;

        // Asynchronous reset in the second substitution cycle.
        in_valid = 1'b1;
        in_block = V_IN;
        tick();
        in_valid = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("async out_valid", out_valid, 1'b0);
        check("async busy", busy, 1'b0);
        check("async in_ready", in_ready, 1'b1);
        check("async out_block", out_block, '0);
        tick();
        reset_n = 1'b1;
        send_expect("after reset", V_IN, V_OUT);

        // Random traffic, checked every cycle by the compare process.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_block  = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_subbytes_seq.md
AES_SUBBYTES_SEQ -- requirements
Module: aes_subbytes_seq

Interface
REQ-001 The block SHALL have parameter NWORDS, default 4, the number of 32-bit words per AES state; only 4 is legal.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning in_block holds a state to substitute.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a state this cycle.
REQ-006 The block SHALL have port in_block, input, 128, the AES state; word 0 = [127:96], word 3 = [31:0].
REQ-007 The block SHALL have port out_valid, output, 1, meaning out_block holds the substituted state.
REQ-008 The block SHALL have port out_ready, input, 1, meaning the downstream stage consumes out_block this cycle.
REQ-009 The block SHALL have port out_block, output, 128, the SubBytes result.
REQ-010 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, SUB and HOLD, plus a 2-bit word counter and a 128-bit state register.
REQ-012 in_ready SHALL equal (FSM == IDLE), and out_valid SHALL equal (FSM == HOLD); both are decoded from registered state, not combinational from inputs.
REQ-013 In IDLE, when in_valid & in_ready is high at an edge, the block SHALL load in_block into the state register, clear the counter and enter SUB.
REQ-014 In SUB, the state word selected by the counter SHALL drive the internal S-box input; at each edge, the S-box output SHALL overwrite that word and the counter SHALL increment.
REQ-015 SUB SHALL last exactly NWORDS (4) cycles, processing words 0,1,2,3 in order; after the counter==3 write, the FSM SHALL enter HOLD.
REQ-016 If the input handshake occurs at edge E0, out_valid SHALL first be high after edge E4, giving a fixed latency of 4 cycles.
REQ-017 In HOLD, out_block SHALL equal the state register and be stable until out_valid & out_ready; at that edge the FSM SHALL return to IDLE.
REQ-018 out_ready held high before HOLD SHALL complete the output handshake on the first out_valid cycle, giving a minimum of 6 cycles per block.
REQ-019 in_valid while busy SHALL be ignored: the state register, counter and FSM are unaffected and no input is queued.
REQ-020 Input and output handshakes SHALL NOT overlap in the same cycle, because in_ready and out_valid are mutually exclusive.
REQ-021 The S-box input SHALL be driven to 32'h0 whenever the FSM is not in SUB.
REQ-022 out_block SHALL show the state register in all FSM states; it is meaningful only while out_valid is high.

Reset
REQ-023 When reset_n is low, the FSM SHALL be in IDLE, the counter 0 and the state register 0, regardless of clk and mid-operation.
REQ-024 Under reset, outputs SHALL be: in_ready 1, out_valid 0, busy 0, out_block 128'h0.
REQ-025 A handshake SHALL NOT be accepted on any edge while reset_n is low.
REQ-026 The first accepting edge SHALL be the first rising edge after reset_n deasserts.

Structure
REQ-027 FSM state encoding and the NWORDS constant SHALL live in the shared package aes_pkg.
REQ-028 The block SHALL instantiate exactly one sub-module, aes_sbox (32-bit word in, 32-bit word out, combinational).
REQ-029 No other S-box logic SHALL be duplicated in this block.

Verification
REQ-030 Directed: in_block 00112233_44556677_8899aabb_ccddeeff -> out_block 638293c3_1bfc33f5_c4eeacea_4bc12816, with out_valid first high 4 edges after the handshake.
REQ-031 Directed: in_block all-zero -> out_block all bytes 8'h63.
REQ-032 Directed: in_block 52000000_00000000_00000000_00000000 -> out_block 00636363_63636363_63636363_63636363, checking word order and byte lanes.
REQ-033 Directed: out_ready low for 10 cycles in HOLD -> out_valid stays 1, out_block stays stable, in_ready stays 0; then one out_ready pulse -> IDLE on the next edge.
REQ-034 Directed: a second in_valid with a different block during SUB -> it is ignored, and the first block's result is unchanged.
REQ-035 Directed: reset_n pulsed low during the 2nd SUB cycle -> out_valid 0, busy 0, in_ready 1 and out_block 0 immediately (asynchronously); the next block then processes normally.
